// File: rtl/mem_copy_engine.sv
// ----------------------------------------------------------------------------
// mem_copy_engine
//
// Block-copy engine placed directly in front of the data memory. While idle
// the core's load/store signals pass straight through to the memory port.
// When started, the engine owns the port and copies `length` bytes from
// `src_addr` to `dst_addr` one byte at a time in ascending order. Each byte
// takes a READ cycle (combinational memory read into a holding register)
// followed by a WRITE cycle (clocked memory write). A FIN cycle pulses `done`
// before the port is returned to the core.
//
// Ports
//   CLK        in   system clock, rising edge active
//   RESET      in   asynchronous active-high reset
//   start      in   copy request, sampled only while idle
//   src_addr   in   first source address
//   dst_addr   in   first destination address
//   length     in   byte count, 0 means no copy
//   cpu_addr   in   core load/store address
//   cpu_wdata  in   core store data
//   cpu_we     in   core store enable
//   mem_rdata  in   combinational read data from the data memory
//   mem_addr   out  address to the data memory
//   mem_wdata  out  write data to the data memory
//   mem_we     out  write enable to the data memory
//   busy       out  engine owns the memory port, core must stall
//   done       out  one-cycle completion pulse
// ----------------------------------------------------------------------------
module mem_copy_engine #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StFin   = 2'd3;

    localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;
    logic [DATA_W-1:0] buf_q,   buf_d;
    logic [ADDR_W-1:0] src_q,   src_d;
    logic [ADDR_W-1:0] dst_q,   dst_d;
    logic [ADDR_W-1:0] len_q,   len_d;

    // Byte pointers; the adds wrap modulo 2^ADDR_W by truncation.
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W-1:0] idx_inc;

    always_comb begin
        src_ptr = src_q + idx_q;
        dst_ptr = dst_q + idx_q;
        idx_inc = idx_q + AddrOne;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // Only the latched copies are used from here on; the
                    // request inputs may change freely after this edge.
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = length;
                    idx_d   = '0;
                    state_d = (length != '0) ? StRead : StFin;
                end
            end
            StRead: begin
                buf_d   = mem_rdata;
                state_d = StWrite;
            end
            StWrite: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == len_q) ? StFin : StRead;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            idx_q   <= '0;
            buf_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
        end
    end

    // ------------------------------------------------------------------------
    // Memory port mux and status outputs
    // ------------------------------------------------------------------------
    // The async reset forces IDLE, so during reset the port follows the core.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
            end
            StRead: begin
                mem_addr  = src_ptr;
                mem_wdata = buf_q;
                mem_we    = 1'b0;
                busy      = 1'b1;
            end
            StWrite: begin
                mem_addr  = dst_ptr;
                mem_wdata = buf_q;
                mem_we    = 1'b1;
                busy      = 1'b1;
            end
            StFin: begin
                // Port stays on the engine side so a held cpu_we cannot leak.
                mem_addr  = src_ptr;
                mem_wdata = buf_q;
                mem_we    = 1'b0;
                busy      = 1'b1;
                done      = 1'b1;
            end
            default: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] src_addr, dst_addr, length;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_we;
    logic [7:0] mem_rdata, mem_addr, mem_wdata;
    logic       mem_we, busy, done;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];   // memory attached to the DUT
    logic [7:0] emem [256];  // reference image

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_image(input string tag);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int a = 0; a < 256; a++) begin
            if (mem[a] !== emem[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        checks++;
        assert (bad == 0) else begin
            errors++;
            $error("FAIL %s bad_bytes=%0d first_addr=%0d observed=%0h expected=%0h",
                   tag, bad, first, mem[first[7:0]], emem[first[7:0]]);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        mem[a]  = v;
        emem[a] = v;
    endtask

    // One full copy transaction with cycle-by-cycle checks of the port.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                            input bit cpu_interf, input string tag);
        logic [7:0] wa_q[$];
        logic [7:0] wd_q[$];
        int         nn;
        int         wi;
        bit         exp_busy, exp_done, exp_we;
        // Reference: sequential ascending byte copy with wrapping addresses.
        for (int i = 0; i < int'(n); i++) begin
            logic [7:0] sa, da;
            sa = s + 8'(i);
            da = d + 8'(i);
            emem[da] = emem[sa];
            wa_q.push_back(da);
            wd_q.push_back(emem[sa]);
        end
        nn = int'(n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        cpu_we   = 1'b0;
        for (int c = 1; c <= 2 * nn + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start    = 1'b0;
                src_addr = 8'($urandom);
                dst_addr = 8'($urandom);
                length   = 8'($urandom);
                if (cpu_interf) begin
                    cpu_addr  = 8'd42;
                    cpu_wdata = 8'($urandom);
                    cpu_we    = 1'b1;
                end
            end
            #1;
            exp_busy = (c <= 2 * nn + 1);
            exp_done = (c == 2 * nn + 1);
            exp_we   = (c % 2 == 0) && (c <= 2 * nn);
            if (c == 2 * nn + 2) exp_we = cpu_we;
            check($sformatf("%s.busy@c%0d", tag, c), 32'(busy), 32'(exp_busy));
            check($sformatf("%s.done@c%0d", tag, c), 32'(done), 32'(exp_done));
            check($sformatf("%s.we@c%0d", tag, c), 32'(mem_we), 32'(exp_we));
            if ((c % 2 == 0) && (c <= 2 * nn)) begin
                wi = c / 2 - 1;
                check($sformatf("%s.waddr%0d", tag, wi), 32'(mem_addr), 32'(wa_q[wi]));
                check($sformatf("%s.wdata%0d", tag, wi), 32'(mem_wdata), 32'(wd_q[wi]));
            end
            if (c == 2 * nn + 2) begin
                check($sformatf("%s.idle_addr", tag), 32'(mem_addr), 32'(cpu_addr));
                check($sformatf("%s.idle_wdata", tag), 32'(mem_wdata), 32'(cpu_wdata));
                cpu_we = 1'b0;
            end
        end
        check_image({tag, ".image"});
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        length    = '0;
        cpu_addr  = 8'h33;
        cpu_wdata = 8'h5a;
        cpu_we    = 1'b0;
        for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom));

        // Reset state and pass-through while in reset.
        #2;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.addr", 32'(mem_addr), 32'h33);
        check("rst.wdata", 32'(mem_wdata), 32'h5a);
        check("rst.we", 32'(mem_we), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic copy.
        poke(8'd16, 8'd1); poke(8'd17, 8'd2); poke(8'd18, 8'd3); poke(8'd19, 8'd4);
        run_copy(8'd16, 8'd64, 8'd4, 1'b0, "basic");
        check("basic.m64", 32'(mem[64]), 32'd1);
        check("basic.m67", 32'(mem[67]), 32'd4);

        // Source wraps through 255 -> 0.
        poke(8'd254, 8'd9); poke(8'd255, 8'd8); poke(8'd0, 8'd7); poke(8'd1, 8'd6);
        run_copy(8'd254, 8'd100, 8'd4, 1'b0, "wrap");
        check("wrap.m102", 32'(mem[102]), 32'd7);
        check("wrap.m103", 32'(mem[103]), 32'd6);

        // Overlapping forward copy propagates the first byte.
        poke(8'd10, 8'd5); poke(8'd11, 8'd6);
        run_copy(8'd10, 8'd11, 8'd3, 1'b0, "overlap");
        check("overlap.m13", 32'(mem[13]), 32'd5);

        // Zero length, and core store held during a copy.
        run_copy(8'd30, 8'd90, 8'd0, 1'b0, "len0");
        poke(8'd42, 8'hc3);
        run_copy(8'd120, 8'd140, 8'd5, 1'b1, "cpu_hold");
        check("cpu_hold.m42", 32'(mem[42]), 32'hc3);
        run_copy(8'd50, 8'd50, 8'd6, 1'b0, "same");

        // Reset during the second WRITE: only the first byte lands.
        poke(8'd16, 8'd11); poke(8'd17, 8'd12);
        poke(8'd18, 8'd13); poke(8'd19, 8'd14);
        emem[64] = emem[16];
        @(negedge clk);
        src_addr = 8'd16;
        dst_addr = 8'd64;
        length   = 8'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);          // cycle 4
        rst = 1'b1;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.done", 32'(done), 32'd0);
        check("abort.we", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_image("abort.image");
        run_copy(8'd16, 8'd64, 8'd4, 1'b0, "after_abort");

        // Randomized copies against the reference model.
        for (int t = 0; t < 12; t++) begin
            logic [7:0] rs, rd, rn;
            rs = 8'($urandom);
            rd = 8'($urandom);
            rn = (t % 4 == 3) ? 8'd0 : 8'($urandom_range(1, 24));
            run_copy(rs, rd, rn, bit'($urandom_range(0, 1)), $sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Block-copy engine that sits directly upstream of the data memory and drives its address, write-data and write-enable inputs. While idle it passes the core's load/store signals through unchanged. When started it takes over the memory port, copies `length` bytes from `src_addr` to `dst_addr` using the memory's combinational read and clocked write, then returns the port to the core and pulses `done`.

## Interface
- `ADDR_W`, 8, address width; the address space is 2^ADDR_W bytes.
- `DATA_W`, 8, data width of one memory word.
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a copy; sampled only in IDLE.
- `src_addr`  in  ADDR_W  first source address.
- `dst_addr`  in  ADDR_W  first destination address.
- `length`  in  ADDR_W  number of bytes to copy; 0 means no copy.
- `cpu_addr`  in  ADDR_W  core load/store address.
- `cpu_wdata`  in  DATA_W  core store data.
- `cpu_we`  in  1  core store enable.
- `mem_rdata`  in  DATA_W  combinational read data from the data memory.
- `mem_addr`  out  ADDR_W  address to the data memory.
- `mem_wdata`  out  DATA_W  write data to the data memory.
- `mem_we`  out  1  write enable to the data memory.
- `busy`  out  1  engine owns the memory port; the core must stall.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, READ, WRITE, FIN.
- **IDLE**
  - `mem_addr` = `cpu_addr`, `mem_wdata` = `cpu_wdata`, `mem_we` = `cpu_we` (purely combinational).
  - On `start`=1, latch `src_addr`, `dst_addr` and `length`, and clear the byte counter `idx`.
  - Next state is READ if `length` != 0, otherwise FIN.
- **READ**
  - `mem_addr` = `src` + `idx`, `mem_we` = 0.
  - At the clock edge, capture `mem_rdata` into the holding register `buf`, then go to WRITE.
- **WRITE**
  - `mem_addr` = `dst` + `idx`, `mem_wdata` = `buf`, `mem_we` = 1.
  - At the clock edge, `idx` increments.
  - If `idx`+1 == `len`, go to FIN; otherwise go to READ.
- **FIN**
  - `done` = 1 and `mem_we` = 0; the memory port mux is still on the engine side.
  - Next state is IDLE unconditionally.
- `busy` = (state != IDLE). While `busy`, the `cpu_*` inputs are ignored and `cpu_we` never reaches memory.
- Address arithmetic is modulo 2^ADDR_W: `src`+`idx` and `dst`+`idx` wrap from 255 to 0. Carries are discarded.
- Copy direction is strictly ascending, one byte at a time.
  - Overlapping regions with `dst` > `src` propagate already-written bytes. This is the specified behaviour.
  - `dst` == `src` rewrites identical values.
- `start` asserted while `busy` is ignored, not queued. `start` held high through FIN starts a new copy on the first IDLE cycle.
- The `src_addr`, `dst_addr` and `length` inputs may change freely after the start cycle; only the latched copies are used.

## Timing
- Reset values: state IDLE; `idx`, `buf`, `src`, `dst` and `len` all 0; `busy`=0; `done`=0.
- During reset the `mem_*` outputs follow the `cpu_*` inputs, because the block is in IDLE.
- Reset asserted mid-copy aborts immediately. Bytes already written remain; no further writes occur, and `done` is not pulsed.
- Start is sampled at edge 0. For N>0:
  - READ runs in cycles 1, 3, …, 2N−1.
  - WRITE runs in cycles 2, 4, …, 2N.
  - FIN, with `done`=1, is cycle 2N+1.
  - IDLE resumes at cycle 2N+2.
  - Total occupancy is 2N+1 cycles with `busy`=1.
- For N=0: FIN in cycle 1, IDLE in cycle 2. No memory write occurs.
- Each write lands at the rising edge ending its WRITE cycle. A READ in the immediately following cycle sees the new value.

## Test plan
- Preload M[16..19] = 1,2,3,4. Start with src=16, dst=64, len=4 → `mem_we` high in cycles 2,4,6,8; `done` in cycle 9; M[64..67] = 1,2,3,4; `busy` high in cycles 1–9.
- src=254, dst=100, len=4 with M[254,255,0,1] = 9,8,7,6 → reads wrap to addresses 0 and 1; M[100..103] = 9,8,7,6.
- Overlap: M[10]=5, M[11]=6. Start with src=10, dst=11, len=3 → M[11..13] = 5,5,5.
- len=0 → `done` in cycle 1, `busy` high for 1 cycle, no `mem_we` pulse, memory unchanged.
- Hold `cpu_we`=1 with `cpu_addr`=42 during a copy → M[42] untouched while `busy`. After return to IDLE, `mem_we` follows `cpu_we` in the same cycle.
- Assert RESET in cycle 4 of a len=4 copy → `busy` and `done` drop immediately, only the first byte has been written, and a subsequent start completes normally.
